// File: rtl/bcd_conv_sched.sv
// Shared shift-and-add-3 binary-to-BCD engine for two round-robin requesters; define BCD_SCHED_FIXED_PRIO_EN for fixed priority (req0 wins ties).
// Latency: result valid WIDTH cycles after accept; valid/ready on both sides, result held indefinitely under out_ready=0.
module bcd_conv_sched #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  input  logic [WIDTH-1:0]      req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [WIDTH-1:0]      req1_data,
  output logic                  req1_ready,
  output logic                  out_valid,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_id,
  input  logic                  out_ready,
  output logic                  busy
);

  localparam int BW = 4*DIGITS;
  localparam int SW = BW + WIDTH;
  localparam int CW = $clog2(WIDTH+1);

  typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   sr_q, sr_d;
  logic [BW-1:0]   out_bcd_q, out_bcd_d;
  logic            out_id_q, out_id_d;
  logic            out_valid_q, out_valid_d;
  logic            last_q, last_d;

  logic            gnt0, gnt1;
  logic [SW-1:0]   sr_adj, sr_shift;

  always_comb begin
`ifdef BCD_SCHED_FIXED_PRIO_EN
    gnt0 = req0_valid;
`else
    // last_q==1 means requester 1 was served most recently, so req0 wins a tie
    gnt0 = req0_valid && (!req1_valid || last_q);
`endif
    gnt1 = req1_valid && !gnt0;
  end

  assign req0_ready = (state_q == IDLE) && gnt0;
  assign req1_ready = (state_q == IDLE) && gnt1;

  always_comb begin
    sr_adj = sr_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (sr_q[WIDTH+4*i +: 4] >= 4'd5)
        sr_adj[WIDTH+4*i +: 4] = sr_q[WIDTH+4*i +: 4] + 4'd3;
    end
    sr_shift = sr_adj << 1;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    out_bcd_d   = out_bcd_q;
    out_id_d    = out_id_q;
    out_valid_d = out_valid_q;
    last_d      = last_q;
    unique case (state_q)
      IDLE: begin
        if (gnt0 || gnt1) begin
          sr_d     = {{BW{1'b0}}, (gnt1 ? req1_data : req0_data)};
          cnt_d    = CW'(WIDTH);
          out_id_d = gnt1;
          last_d   = gnt1;
          state_d  = CONV;
        end
      end
      CONV: begin
        sr_d  = sr_shift;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          out_bcd_d   = sr_shift[SW-1 -: BW];
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sr_q        <= '0;
      out_bcd_q   <= '0;
      out_id_q    <= 1'b0;
      out_valid_q <= 1'b0;
      last_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      out_bcd_q   <= out_bcd_d;
      out_id_q    <= out_id_d;
      out_valid_q <= out_valid_d;
      last_q      <= last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_bcd   = out_bcd_q;
  assign out_id    = out_id_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Directed bench for bcd_conv_sched: single conversions, tie arbitration, backpressure, sweep, resets, valid withdrawal.
module tb_bcd_conv_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [7:0]  req0_data, req1_data;
  logic        out_valid, out_id, out_ready, busy;
  logic [11:0] out_bcd;

  int n_cmp = 0;
  int n_err = 0;

  bcd_conv_sched #(.WIDTH(8), .DIGITS(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_bcd(out_bcd), .out_id(out_id),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] dec_ref(input int v);
    dec_ref = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = '0; req1_data = '0;
    out_ready = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    #1;
  endtask

  // Present one request, wait for acceptance, then count cycles until out_valid.
  task automatic send(input logic id, input logic [7:0] v, output int lat);
    int n;
    if (id) begin req1_valid = 1'b1; req1_data = v; end
    else    begin req0_valid = 1'b1; req0_data = v; end
    #1;
    n = 0;
    while (!(id ? req1_ready : req0_ready) && n < 50) begin tick(); n++; end
    chk("accept", {31'b0, (id ? req1_ready : req0_ready)}, 32'd1);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin tick(); lat++; end
  endtask

  task automatic convert_one(input string tag, input logic id, input logic [7:0] v,
                             input logic [11:0] exp_bcd);
    int lat;
    out_ready = 1'b1;
    send(id, v, lat);
    chk({tag, "_lat"}, lat, 32'd8);
    chk({tag, "_bcd"}, {20'b0, out_bcd}, {20'b0, exp_bcd});
    chk({tag, "_id"}, {31'b0, out_id}, {31'b0, id});
    tick();
    chk({tag, "_done"}, {31'b0, out_valid}, 32'd0);
  endtask

  task automatic drain();
    int n;
    req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b1;
    #1;
    n = 0;
    while ((busy || out_valid) && n < 50) begin tick(); n++; end
    chk("drain_busy", {31'b0, busy}, 32'd0);
  endtask

  int          acc_t[4];
  logic        r_id[4];
  logic [11:0] r_bcd[4];
  logic        exp_id;
  int          na, nr, cyc, lat;
  bit          ok;

  initial begin
    do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_bcd",   {20'b0, out_bcd},   32'd0);
    chk("rst_id",    {31'b0, out_id},    32'd0);
    chk("rst_busy",  {31'b0, busy},      32'd0);
    rst_n = 1'b1;
    #1;

    convert_one("c255", 1'b0, 8'd255, 12'h255);
    convert_one("c0",   1'b0, 8'd0,   12'h000);
    convert_one("c99",  1'b0, 8'd99,  12'h099);

    // Tie arbitration with both requesters valid continuously
    do_reset();
    req0_valid = 1'b1; req0_data = 8'd12;
    req1_valid = 1'b1; req1_data = 8'd200;
    #1;
    na = 0; nr = 0; cyc = 0;
    while (nr < 4 && cyc < 100) begin
      if ((req0_ready || req1_ready) && na < 4) begin acc_t[na] = cyc; na++; end
      if (out_valid) begin r_id[nr] = out_id; r_bcd[nr] = out_bcd; nr++; end
      tick(); cyc++;
    end
    chk("tie_nres", nr, 32'd4);
    for (int i = 0; i < 4; i++) begin
`ifdef BCD_SCHED_FIXED_PRIO_EN
      exp_id = 1'b0;
`else
      exp_id = i[0];
`endif
      chk("tie_id",  {31'b0, r_id[i]},  {31'b0, exp_id});
      chk("tie_bcd", {20'b0, r_bcd[i]}, exp_id ? 32'h200 : 32'h012);
    end
    chk("tie_gap1", acc_t[1] - acc_t[0], 32'd10);
    chk("tie_gap2", acc_t[2] - acc_t[1], 32'd10);
    drain();

    // Backpressure: result held, no acceptance while waiting
    do_reset();
    out_ready = 1'b0;
    send(1'b1, 8'd128, lat);
    chk("bp_lat", lat, 32'd8);
    req0_valid = 1'b1; req1_valid = 1'b1; req0_data = 8'd7; req1_data = 8'd9;
    #1;
    ok = 1'b1;
    repeat (20) begin
      if (!out_valid || out_bcd !== 12'h128 || out_id !== 1'b1 ||
          req0_ready || req1_ready || !busy) ok = 1'b0;
      tick();
    end
    chk("bp_hold", {31'b0, ok}, 32'd1);
    req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("bp_idle",  {31'b0, busy},      32'd0);
    chk("bp_valid", {31'b0, out_valid}, 32'd0);
    chk("bp_keep",  {20'b0, out_bcd},   32'h128);
    chk("bp_keepid",{31'b0, out_id},    32'd1);

    // Sweep all values, alternating requesters
    do_reset();
    for (int v = 0; v < 256; v++)
      convert_one("sweep", v[0], v[7:0], dec_ref(v));

    // Reset while holding a result
    do_reset();
    out_ready = 1'b0;
    send(1'b0, 8'd173, lat);
    chk("hold_bcd", {20'b0, out_bcd}, 32'h173);
    #2 rst_n = 1'b0;
    #1;
    chk("rsthold_valid", {31'b0, out_valid}, 32'd0);
    chk("rsthold_busy",  {31'b0, busy},      32'd0);
    chk("rsthold_bcd",   {20'b0, out_bcd},   32'd0);
    tick();
    rst_n = 1'b1; out_ready = 1'b1;
    #1;

    // Reset in the middle of a conversion
    req0_valid = 1'b1; req0_data = 8'd173;
    #1;
    chk("midc_acc", {31'b0, req0_ready}, 32'd1);
    tick();
    req0_valid = 1'b0;
    repeat (4) tick();
    chk("midc_busy_pre", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midc_valid", {31'b0, out_valid}, 32'd0);
    chk("midc_busy",  {31'b0, busy},      32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    ok = 1'b1;
    repeat (15) begin
      if (out_valid || busy) ok = 1'b0;
      tick();
    end
    chk("midc_nostale", {31'b0, ok}, 32'd1);
    req0_valid = 1'b1; req0_data = 8'd1;
    req1_valid = 1'b1; req1_data = 8'd2;
    #1;
    chk("midc_tie_r0", {31'b0, req0_ready}, 32'd1);
    chk("midc_tie_r1", {31'b0, req1_ready}, 32'd0);
    drain();

    // Valid withdrawal during CONV leaves the pointer alone
    do_reset();
    req0_valid = 1'b1; req0_data = 8'd42;
    #1;
    tick();
    req0_valid = 1'b0;
    tick();
    req1_valid = 1'b1; req1_data = 8'd77;
    #1;
    chk("wd_r1_blocked", {31'b0, req1_ready}, 32'd0);
    tick();
    req1_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin tick(); lat++; end
    chk("wd_bcd", {20'b0, out_bcd}, 32'h042);
    chk("wd_id",  {31'b0, out_id},  32'd0);
    tick();
    chk("wd_idle", {31'b0, busy}, 32'd0);
    req0_valid = 1'b1; req0_data = 8'd5;
    req1_valid = 1'b1; req1_data = 8'd6;
    #1;
`ifdef BCD_SCHED_FIXED_PRIO_EN
    chk("wd_tie_r0", {31'b0, req0_ready}, 32'd1);
    chk("wd_tie_r1", {31'b0, req1_ready}, 32'd0);
`else
    chk("wd_tie_r0", {31'b0, req0_ready}, 32'd0);
    chk("wd_tie_r1", {31'b0, req1_ready}, 32'd1);
`endif
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
